vm_seq: RTL and testbench

Front-end sequencer for the one-hot vending core (inputs `a`/`b`, registered `change[2:0]`). It collects coin pulses from two coin slots, arbitrates them round-robin onto the core's single coin input, and issues cancel requests. It mirrors the core's credit so it can tell a sale from an idle cycle, then runs the hopper payout handshake (one coin per transfer) or the product dispense handshake.

---
 rtl/vm_seq_if.sv | 27 ++
 rtl/vm_seq.sv | 117 +++++++++++
 tb/tb_vm_seq.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vm_seq_if.sv
// rtl/vm_seq_if.sv - coin, cancel, hopper and dispenser signals between vm_seq and its surroundings
interface vm_seq_if;
   logic       coin_a;
   logic       coin_b;
   logic       cancel;
   logic [2:0] change;
   logic       vm_a;
   logic       vm_b;
   logic       pay_valid;
   logic       pay_ready;
   logic       dispense_req;
   logic       dispense_ack;
   logic [2:0] credit;
   logic       busy;
   logic       ovf;
   logic       err;

   modport master (
      input  coin_a, coin_b, cancel, change, pay_ready, dispense_ack,
      output vm_a, vm_b, pay_valid, dispense_req, credit, busy, ovf, err
   );

   modport slave (
      output coin_a, coin_b, cancel, change, pay_ready, dispense_ack,
      input  vm_a, vm_b, pay_valid, dispense_req, credit, busy, ovf, err
   );
endinterface

// File: rtl/vm_seq.sv
// rtl/vm_seq.sv - round-robin coin arbiter, cancel and payout/dispense sequencer for the vending core
module vm_seq #(
   parameter int PRICE = 5,
   parameter int CW    = 3
) (
   input  logic     clk,
   input  logic     rst_n,
   vm_seq_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, ISSUE_A, ISSUE_B, GAP, CAPTURE, PAYOUT, DISPENSE
   } state_t;

   localparam logic [CW-1:0] CNT_MAX    = '1;
   localparam logic [2:0]    CREDIT_TOP = 3'(PRICE - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] pa, pb;
   logic          pc;
   logic          last_b;
   logic [2:0]    pay_cnt;
   logic [2:0]    credit;
   logic          vm_a, vm_b, pay_valid, dispense_req, ovf, err;
   logic          grant_a, grant_b, xfer, ovf_set;

   // A grant and a new coin on the same slot cancel out, even when saturated
   function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                              input logic inc, input logic dec);
      logic [CW-1:0] r;
      r = c;
      if (inc && !dec && c != CNT_MAX) r = c + CW'(1);
      else if (dec && !inc)            r = c - CW'(1);
      return r;
   endfunction

   always_comb begin
      state_nxt = state;
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      unique case (state)
         IDLE: begin
            if (pa != '0 || pb != '0) begin
               state_nxt = ISSUE_A;
               if (pa != '0 && pb != '0) begin
                  grant_a = last_b;
                  grant_b = !last_b;
               end else begin
                  grant_a = (pa != '0);
                  grant_b = (pa == '0);
               end
            end else if (pc) begin
               state_nxt = ISSUE_B;
            end
         end
         ISSUE_A:  state_nxt = (credit == CREDIT_TOP) ? GAP : IDLE;
         ISSUE_B:  state_nxt = CAPTURE;
         CAPTURE:  state_nxt = (bus.change != 3'd0) ? PAYOUT : IDLE;
         GAP:      state_nxt = DISPENSE;
         PAYOUT:   if (xfer && pay_cnt == 3'd1) state_nxt = IDLE;
         DISPENSE: if (bus.dispense_ack) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   assign xfer    = (state == PAYOUT) && pay_valid && bus.pay_ready;
   assign ovf_set = (bus.coin_a && pa == CNT_MAX && !grant_a) ||
                    (bus.coin_b && pb == CNT_MAX && !grant_b);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         pa           <= '0;
         pb           <= '0;
         pc           <= 1'b0;
         last_b       <= 1'b1;
         pay_cnt      <= 3'd0;
         credit       <= 3'd0;
         vm_a         <= 1'b0;
         vm_b         <= 1'b0;
         pay_valid    <= 1'b0;
         dispense_req <= 1'b0;
         ovf          <= 1'b0;
         err          <= 1'b0;
      end else begin
         state        <= state_nxt;
         pa           <= cnt_next(pa, bus.coin_a, grant_a);
         pb           <= cnt_next(pb, bus.coin_b, grant_b);
         pc           <= bus.cancel | (pc & (state != ISSUE_B));
         ovf          <= ovf | ovf_set;
         vm_a         <= (state_nxt == ISSUE_A);
         vm_b         <= (state_nxt == ISSUE_B);
         pay_valid    <= (state_nxt == PAYOUT);
         dispense_req <= (state_nxt == DISPENSE);
         if (grant_a)      last_b <= 1'b0;
         else if (grant_b) last_b <= 1'b1;
         if (state == ISSUE_A)
            credit <= (credit == CREDIT_TOP) ? 3'd0 : credit + 3'd1;
         // The core's change is trusted over our mirror; a disagreement is only flagged
         if (state == CAPTURE) begin
            pay_cnt <= bus.change;
            credit  <= 3'd0;
            if (bus.change != credit) err <= 1'b1;
         end else if (xfer) begin
            pay_cnt <= pay_cnt - 3'd1;
         end
      end
   end

   assign bus.vm_a         = vm_a;
   assign bus.vm_b         = vm_b;
   assign bus.pay_valid    = pay_valid;
   assign bus.dispense_req = dispense_req;
   assign bus.credit       = credit;
   assign bus.busy         = (state != IDLE);
   assign bus.ovf          = ovf;
   assign bus.err          = err;
endmodule

// File: tb/tb_vm_seq.sv
// tb/tb_vm_seq.sv - scoreboard bench for vm_seq with a vending-core model, hopper and dispenser responders
module tb_vm_seq;
   localparam int PRICE  = 5;
   localparam int K_VMA  = 0;
   localparam int K_VMB  = 1;
   localparam int K_DISP = 2;
   localparam int K_PAY  = 3;

   typedef struct {
      int kind;
      int val;
   } evt_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   vm_seq_if bus();

   vm_seq #(.PRICE(PRICE), .CW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   evt_t sb[$];
   int   credit_m = 0;
   bit   hold_ack = 1'b0;
   bit   pay_rand = 1'b1;
   bit   inj_en   = 1'b0;
   int   inj_val  = 0;
   bit   rec_pp   = 1'b0;
   int   pp_q[$];
   int   pp_exp[$];
   int   vma_q[$];
   int   mcyc = 0;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_evt(input int k, input int v);
      evt_t e;
      e.kind = k;
      e.val  = v;
      sb.push_back(e);
   endtask

   // Reference: every coin adds one credit; reaching PRICE is a sale, a cancel refunds
   task automatic m_coin();
      push_evt(K_VMA, credit_m);
      credit_m = (credit_m + 1) % PRICE;
      if (credit_m == 0) push_evt(K_DISP, 0);
   endtask

   task automatic m_cancel(input int paid);
      push_evt(K_VMB, credit_m);
      for (int k = paid - 1; k >= 0; k--) push_evt(K_PAY, k);
      credit_m = 0;
   endtask

   task automatic rr_model(input int ea, input int eb, input bit lastb);
      bit ga;
      while (ea > 0 || eb > 0) begin
         if (ea > 0 && eb > 0) ga = lastb;
         else                  ga = (ea > 0);
         if (ga) begin ea--; lastb = 1'b0; end
         else    begin eb--; lastb = 1'b1; end
         pp_exp.push_back(ea * 8 + eb);
      end
   endtask

   task automatic pop_evt(input string nm, input int kind, output int val);
      evt_t e;
      val = -1;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: got unexpected event kind %0d expected none", nm, kind);
      end else begin
         e = sb.pop_front();
         check({nm, "_kind"}, kind, e.kind);
         val = e.val;
      end
   endtask

   task automatic drive(input bit a, input bit b, input bit c);
      bus.coin_a = a;
      bus.coin_b = b;
      bus.cancel = c;
      tick();
      bus.coin_a = 1'b0;
      bus.coin_b = 1'b0;
      bus.cancel = 1'b0;
   endtask

   task automatic coin_cyc(input bit a, input bit b, input bit c);
      if (a) m_coin();
      if (b) m_coin();
      if (c) m_cancel(credit_m);
      drive(a, b, c);
   endtask

   task automatic wait_quiet(input string nm);
      int q = 0;
      int n = 0;
      while (q < 3 && n < 400) begin
         @(negedge clk);
         n++;
         if (sb.size() == 0 && !bus.busy) q++;
         else q = 0;
      end
      check({nm, "_quiet"}, (q >= 3) ? 1 : 0, 1);
      tick();
   endtask

   task automatic wait_req();
      bit ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = bus.dispense_req;
      end
      check("reach_dispense", ok, 1);
      tick();
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      sb.delete();
      credit_m = 0;
      inj_en   = 1'b0;
      hold_ack = 1'b0;
      pay_rand = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Vending core: counts coins modulo PRICE, registers the refund on its b input
   initial begin
      bit va, vb, rn;
      int ccr;
      ccr = 0;
      bus.change = 3'd0;
      forever begin
         @(negedge clk);
         va = bus.vm_a;
         vb = bus.vm_b;
         rn = rst_n;
         @(posedge clk);
         #1;
         if (!rn) begin
            ccr = 0;
            bus.change = 3'd0;
         end else begin
            if (va) ccr = (ccr + 1) % PRICE;
            if (vb) begin
               bus.change = inj_en ? 3'(inj_val) : 3'(ccr);
               ccr = 0;
            end
         end
      end
   end

   // Dispenser, with stray acks while no request is pending
   initial begin
      bus.dispense_ack = 1'b0;
      forever begin
         tick();
         if (bus.dispense_req && !hold_ack && rst_n) begin
            bus.dispense_ack = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            bus.dispense_ack = 1'b1;
            tick();
            bus.dispense_ack = 1'b0;
         end else begin
            bus.dispense_ack = !bus.dispense_req && ($urandom_range(0, 7) == 0);
         end
      end
   end

   initial begin
      bus.pay_ready = 1'b0;
      forever begin
         tick();
         bus.pay_ready = pay_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
      end
   end

   // Monitor
   initial begin
      bit p_req, p_ack, p_pv, p_xfer;
      int p_k, last_vma, last_vmb, v;
      p_req = 0; p_ack = 0; p_pv = 0; p_xfer = 0; p_k = 0;
      last_vma = -100; last_vmb = -100;
      forever begin
         @(negedge clk);
         mcyc++;
         if (!rst_n) begin
            p_req = 0; p_ack = 0; p_pv = 0; p_xfer = 0; p_k = 0;
            last_vma = -100; last_vmb = -100;
         end else begin
            if (bus.vm_a) begin
               check("vma_gap", (mcyc - last_vma >= 2) ? 1 : 0, 1);
               pop_evt("vm_a", K_VMA, v);
               if (v >= 0) check("vm_a_credit", bus.credit, v);
               last_vma = mcyc;
               vma_q.push_back(mcyc);
               if (rec_pp) pp_q.push_back(int'({dut.pa, dut.pb}));
            end
            if (bus.vm_b) begin
               pop_evt("vm_b", K_VMB, v);
               if (v >= 0) check("vm_b_credit", bus.credit, v);
               last_vmb = mcyc;
            end
            if (bus.dispense_req && !p_req) begin
               pop_evt("dispense", K_DISP, v);
               check("sale_to_dispense", mcyc - last_vma, 2);
            end
            if (p_req) check("dispense_hold", bus.dispense_req, p_ack ? 0 : 1);
            if (bus.pay_valid && !p_pv) check("cancel_to_pay", mcyc - last_vmb, 2);
            if (p_xfer) check("pay_valid_after_xfer", bus.pay_valid, (p_k != 0) ? 1 : 0);
            p_xfer = 0;
            if (bus.pay_valid && bus.pay_ready) begin
               pop_evt("pay", K_PAY, v);
               p_k    = v;
               p_xfer = 1;
            end
            p_req = bus.dispense_req;
            p_ack = bus.dispense_ack;
            p_pv  = bus.pay_valid;
         end
      end
   end

   task automatic run_random();
      int n, na, nb;
      bit a, b, c;
      do_reset();
      for (int ph = 0; ph < 30; ph++) begin
         n  = $urandom_range(1, 8);
         na = 0;
         nb = 0;
         for (int i = 0; i < n; i++) begin
            a = ($urandom_range(0, 2) == 0) && (na < 6);
            b = ($urandom_range(0, 2) == 0) && (nb < 6);
            c = (i == n - 1) && ($urandom_range(0, 2) == 0);
            na += int'(a);
            nb += int'(b);
            coin_cyc(a, b, c);
         end
         wait_quiet("rand");
      end
      check("rand_ovf", bus.ovf, 0);
      check("rand_err", bus.err, 0);
   endtask

   initial begin
      int t0;
      bit ok;
      bus.coin_a = 1'b0;
      bus.coin_b = 1'b0;
      bus.cancel = 1'b0;

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_outputs", int'({bus.vm_a, bus.vm_b, bus.pay_valid, bus.dispense_req,
                                 bus.busy, bus.ovf, bus.err}), 0);
      check("rst_credit", bus.credit, 0);
      check("rst_counters", int'({dut.pa, dut.pb, dut.pc, dut.pay_cnt}), 0);
      tick();

      // Five back-to-back coins: latency, spacing and a sale
      vma_q.delete();
      t0 = mcyc + 1;
      for (int i = 0; i < 5; i++) coin_cyc(1'b1, 1'b0, 1'b0);
      wait_quiet("five_coins");
      check("five_vma_count", vma_q.size(), 5);
      if (vma_q.size() == 5) begin
         check("coin_latency", vma_q[0] - t0, 2);
         for (int i = 1; i < 5; i++) check("vma_spacing", vma_q[i] - vma_q[i-1], 2);
      end
      check("five_credit_end", bus.credit, 0);

      // Three coins then cancel: three hopper transfers
      for (int i = 0; i < 3; i++) coin_cyc(1'b1, 1'b0, 1'b0);
      coin_cyc(1'b0, 1'b0, 1'b1);
      wait_quiet("cancel3");
      check("cancel3_err", bus.err, 0);
      check("cancel3_pay_valid", bus.pay_valid, 0);

      // Round robin: same-cycle pulses from reset, then both slots loaded during a held dispense
      do_reset();
      pp_q.delete();
      pp_exp.delete();
      rec_pp = 1'b1;
      coin_cyc(1'b1, 1'b1, 1'b0);
      wait_quiet("rr_first");
      rec_pp = 1'b0;
      rr_model(1, 1, 1'b1);
      hold_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         coin_cyc(1'b1, 1'b0, 1'b0);
         repeat (3) tick();
      end
      wait_req();
      rec_pp = 1'b1;
      for (int i = 0; i < 3; i++) coin_cyc(1'b1, 1'b1, 1'b0);
      rr_model(3, 3, 1'b0);
      hold_ack = 1'b0;
      wait_quiet("rr_held");
      rec_pp = 1'b0;
      check("rr_grants", pp_q.size(), pp_exp.size());
      for (int i = 0; i < pp_q.size() && i < pp_exp.size(); i++)
         check("rr_pa_pb", pp_q[i], pp_exp[i]);
      check("rr_drained", int'({dut.pa, dut.pb}), 0);

      // Saturation: 8 slot-B coins while the dispense is held
      do_reset();
      hold_ack = 1'b1;
      for (int i = 0; i < 5; i++) coin_cyc(1'b1, 1'b0, 1'b0);
      wait_req();
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) m_coin();
      check("ovf_pb", dut.pb, 7);
      check("ovf_flag", bus.ovf, 1);
      hold_ack = 1'b0;
      wait_quiet("ovf_drain");
      check("ovf_sticky", bus.ovf, 1);
      check("ovf_pb_empty", dut.pb, 0);

      // Cancel with two coins pending; then cancel at zero credit
      do_reset();
      hold_ack = 1'b1;
      for (int i = 0; i < 5; i++) coin_cyc(1'b1, 1'b0, 1'b0);
      wait_req();
      coin_cyc(1'b1, 1'b0, 1'b0);
      coin_cyc(1'b1, 1'b0, 1'b1);
      check("pending_pa", dut.pa, 2);
      hold_ack = 1'b0;
      wait_quiet("cancel_pending");
      coin_cyc(1'b0, 1'b0, 1'b1);
      wait_quiet("cancel_zero");
      check("cancel_zero_err", bus.err, 0);

      run_random();

      // Reset during the second PAYOUT cycle
      do_reset();
      pay_rand = 1'b0;
      for (int i = 0; i < 3; i++) coin_cyc(1'b1, 1'b0, 1'b0);
      coin_cyc(1'b0, 1'b0, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = bus.pay_valid;
      end
      check("reach_payout", ok, 1);
      tick();
      rst_n = 1'b0;
      sb.delete();
      credit_m = 0;
      tick();
      @(negedge clk);
      check("midrst_pay_valid", bus.pay_valid, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_credit", bus.credit, 0);
      check("midrst_counters", int'({dut.pa, dut.pb, dut.pc, dut.pay_cnt}), 0);
      tick();
      rst_n = 1'b1;
      pay_rand = 1'b1;

      // Core reports change 2 against a mirrored credit of 1
      do_reset();
      inj_en  = 1'b1;
      inj_val = 2;
      coin_cyc(1'b1, 1'b0, 1'b0);
      m_cancel(2);
      drive(1'b0, 1'b0, 1'b1);
      wait_quiet("bad_change");
      check("bad_change_err", bus.err, 1);
      inj_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
